// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with one word per line.
// Optional hit/miss counters: define DIRECT_MAPPED_CACHE_STATS_EN.
module direct_mapped_cache #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 3,
  parameter int INDEX_WIDTH   = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [ADDRESS_WIDTH-1:0] address_0_i,
  input  logic                     address_valid_0_i,
  input  logic [DATA_WIDTH-1:0]    write_data_0_i,
  input  logic                     write_data_valid_0_i,
  input  logic                     read_write_select_0_i,
  output logic [DATA_WIDTH-1:0]    read_data_0_o,
  output logic                     read_data_valid_0_o,
  output logic                     write_done_0_o,
  output logic                     port_ready_0_o,
  output logic [ADDRESS_WIDTH-1:0] mem_address_0_o,
  output logic                     mem_address_valid_0_o,
  output logic [DATA_WIDTH-1:0]    mem_write_data_0_o,
  output logic                     mem_write_data_valid_0_o,
  output logic                     mem_read_write_select_0_o,
  input  logic [DATA_WIDTH-1:0]    mem_read_data_0_i,
  input  logic                     mem_read_data_valid_0_i,
  input  logic                     mem_write_done_0_i,
  input  logic                     mem_port_ready_0_i
`ifdef DIRECT_MAPPED_CACHE_STATS_EN
  ,
  output logic [15:0]              hit_count_o,
  output logic [15:0]              miss_count_o
`endif
);

  localparam int TAG_WIDTH = ADDRESS_WIDTH - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT} state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0]    req_data_q;
  logic                     req_write_q;
  logic [LINES-1:0]         valid_q;
  logic [TAG_WIDTH-1:0]     tag_q  [LINES];
  logic [DATA_WIDTH-1:0]    data_q [LINES];
  logic [DATA_WIDTH-1:0]    read_data_q;
  logic                     read_data_valid_q;
  logic                     write_done_q;
  logic                     port_ready_q;
  logic                     mem_valid_q;

  logic [INDEX_WIDTH-1:0]   req_index;
  logic [TAG_WIDTH-1:0]     req_tag;
  logic                     hit;
  logic                     accept;
  logic                     line_we;
  logic [DATA_WIDTH-1:0]    line_wdata;

  assign req_index  = req_addr_q[INDEX_WIDTH-1:0];
  assign req_tag    = req_addr_q[ADDRESS_WIDTH-1:INDEX_WIDTH];
  assign hit        = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign accept     = address_valid_0_i && (!read_write_select_0_i || write_data_valid_0_i);
  // Line is written on a write hit in LOOKUP, or filled when a read miss returns.
  assign line_we    = ((state_q == LOOKUP) && req_write_q && hit) ||
                      ((state_q == MEM_WAIT) && !req_write_q && mem_read_data_valid_0_i);
  assign line_wdata = req_write_q ? req_data_q : mem_read_data_0_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!reset_n_i) begin
      state_q           <= IDLE;
      req_addr_q        <= '0;
      req_data_q        <= '0;
      req_write_q       <= 1'b0;
      valid_q           <= '0;
      read_data_q       <= '0;
      read_data_valid_q <= 1'b0;
      write_done_q      <= 1'b0;
      port_ready_q      <= 1'b1;
      mem_valid_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          req_addr_q        <= address_0_i;
          req_data_q        <= write_data_0_i;
          req_write_q       <= read_write_select_0_i;
          read_data_valid_q <= 1'b0;
          write_done_q      <= 1'b0;
          port_ready_q      <= 1'b0;
          state_q           <= LOOKUP;
        end
        LOOKUP: if (!req_write_q && hit) begin
          read_data_q       <= data_q[req_index];
          read_data_valid_q <= 1'b1;
          port_ready_q      <= 1'b1;
          state_q           <= IDLE;
        end else begin
          mem_valid_q <= 1'b1;
          state_q     <= MEM_REQ;
        end
        MEM_REQ: if (mem_port_ready_0_i) begin
          mem_valid_q <= 1'b0;
          state_q     <= MEM_WAIT;
        end
        MEM_WAIT: if (req_write_q) begin
          if (mem_write_done_0_i) begin
            write_done_q <= 1'b1;
            port_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end else if (mem_read_data_valid_0_i) begin
          valid_q[req_index] <= 1'b1;
          read_data_q        <= mem_read_data_0_i;
          read_data_valid_q  <= 1'b1;
          port_ready_q       <= 1'b1;
          state_q            <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag/data storage is deliberately unreset; the valid bits alone guard it.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      tag_q[req_index]  <= req_tag;
      data_q[req_index] <= line_wdata;
    end
  end

  assign read_data_0_o             = read_data_q;
  assign read_data_valid_0_o       = read_data_valid_q;
  assign write_done_0_o            = write_done_q;
  assign port_ready_0_o            = port_ready_q;
  assign mem_address_0_o           = req_addr_q;
  assign mem_address_valid_0_o     = mem_valid_q;
  assign mem_write_data_0_o        = req_data_q;
  assign mem_write_data_valid_0_o  = mem_valid_q & req_write_q;
  assign mem_read_write_select_0_o = req_write_q;

`ifdef DIRECT_MAPPED_CACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
      end else if (miss_count_q != 16'hFFFF) begin
        miss_count_q <= miss_count_q + 16'd1;
      end
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Directed bench for direct_mapped_cache against a sticky-flag memory model
// (read latency 9, write latency 14). Contents reload to 0x0100+addr on reset.
module tb_direct_mapped_cache;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [2:0]  address_0_i;
  logic        address_valid_0_i;
  logic [15:0] write_data_0_i;
  logic        write_data_valid_0_i;
  logic        read_write_select_0_i;
  logic [15:0] read_data_0_o;
  logic        read_data_valid_0_o;
  logic        write_done_0_o;
  logic        port_ready_0_o;
  logic [2:0]  mem_address_0_o;
  logic        mem_address_valid_0_o;
  logic [15:0] mem_write_data_0_o;
  logic        mem_write_data_valid_0_o;
  logic        mem_read_write_select_0_o;
  logic [15:0] mem_read_data_0_i;
  logic        mem_read_data_valid_0_i;
  logic        mem_write_done_0_i;
  logic        mem_port_ready_0_i;
`ifdef DIRECT_MAPPED_CACHE_STATS_EN
  logic [15:0] hit_count_o;
  logic [15:0] miss_count_o;
`endif

  direct_mapped_cache dut (
    .clk_i                     (clk_i),
    .reset_n_i                 (reset_n_i),
    .address_0_i               (address_0_i),
    .address_valid_0_i         (address_valid_0_i),
    .write_data_0_i            (write_data_0_i),
    .write_data_valid_0_i      (write_data_valid_0_i),
    .read_write_select_0_i     (read_write_select_0_i),
    .read_data_0_o             (read_data_0_o),
    .read_data_valid_0_o       (read_data_valid_0_o),
    .write_done_0_o            (write_done_0_o),
    .port_ready_0_o            (port_ready_0_o),
    .mem_address_0_o           (mem_address_0_o),
    .mem_address_valid_0_o     (mem_address_valid_0_o),
    .mem_write_data_0_o        (mem_write_data_0_o),
    .mem_write_data_valid_0_o  (mem_write_data_valid_0_o),
    .mem_read_write_select_0_o (mem_read_write_select_0_o),
    .mem_read_data_0_i         (mem_read_data_0_i),
    .mem_read_data_valid_0_i   (mem_read_data_valid_0_i),
    .mem_write_done_0_i        (mem_write_done_0_i),
    .mem_port_ready_0_i        (mem_port_ready_0_i)
`ifdef DIRECT_MAPPED_CACHE_STATS_EN
    ,
    .hit_count_o               (hit_count_o),
    .miss_count_o              (miss_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // ---------------- memory model ----------------
  localparam int READ_LAT  = 9;
  localparam int WRITE_LAT = 14;

  logic [15:0] mem_q [8];
  logic        m_busy;
  logic        m_write;
  logic [2:0]  m_addr;
  logic [15:0] m_data;
  int          m_cnt;
  int          mem_reads  = 0;
  int          mem_writes = 0;
  logic        m_accept;

  assign m_accept = mem_port_ready_0_i && mem_address_valid_0_o &&
                    (!mem_read_write_select_0_o || mem_write_data_valid_0_o);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= 16'h0100 + 16'(i);
      mem_port_ready_0_i      <= 1'b1;
      mem_read_data_valid_0_i <= 1'b0;
      mem_write_done_0_i      <= 1'b0;
      mem_read_data_0_i       <= '0;
      m_busy                  <= 1'b0;
      m_write                 <= 1'b0;
      m_addr                  <= '0;
      m_data                  <= '0;
      m_cnt                   <= 0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        if (m_write) begin
          mem_q[m_addr]      <= m_data;
          mem_write_done_0_i <= 1'b1;
        end else begin
          mem_read_data_0_i       <= mem_q[m_addr];
          mem_read_data_valid_0_i <= 1'b1;
        end
        m_busy             <= 1'b0;
        mem_port_ready_0_i <= 1'b1;
      end
    end else if (m_accept) begin
      mem_read_data_valid_0_i <= 1'b0;
      mem_write_done_0_i      <= 1'b0;
      mem_port_ready_0_i      <= 1'b0;
      m_busy                  <= 1'b1;
      m_write                 <= mem_read_write_select_0_o;
      m_addr                  <= mem_address_0_o;
      m_data                  <= mem_write_data_0_o;
      m_cnt                   <= mem_read_write_select_0_o ? WRITE_LAT : READ_LAT;
    end
  end

  always @(posedge clk_i) begin
    if (reset_n_i && !m_busy && m_accept) begin
      if (mem_read_write_select_0_o) mem_writes <= mem_writes + 1;
      else                           mem_reads  <= mem_reads + 1;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge; edges counts posedges from the accept edge (edge 1)
  // up to the one after which the response flag is seen.
  task automatic do_req(input logic wr, input logic [2:0] a, input logic [15:0] d,
                        output int edges, output logic timed_out, output logic mem_seen);
    @(negedge clk_i);
    address_0_i           = a;
    address_valid_0_i     = 1'b1;
    read_write_select_0_i = wr;
    write_data_0_i        = d;
    write_data_valid_0_i  = wr;
    @(posedge clk_i);
    edges = 1;
    @(negedge clk_i);
    address_valid_0_i    = 1'b0;
    write_data_valid_0_i = 1'b0;
    timed_out = 1'b1;
    mem_seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mem_address_valid_0_o) mem_seen = 1'b1;
      if (wr ? write_done_0_o : read_data_valid_0_o) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk_i);
      edges++;
      @(negedge clk_i);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t vec [12];

  initial begin
    int          edges, rd0, wr0;
    logic        to, seen;
    logic [15:0] last_rd;

    vec[0]  = '{1'b1, 3'd5, 16'hBEEF, 16'h0000, 1'b0}; // write miss
    vec[1]  = '{1'b0, 3'd5, 16'h0000, 16'hBEEF, 1'b0}; // no allocate -> read miss
    vec[2]  = '{1'b0, 3'd5, 16'h0000, 16'hBEEF, 1'b1}; // read hit
    vec[3]  = '{1'b1, 3'd1, 16'h1111, 16'h0000, 1'b0}; // index 1 holds tag of addr 5
    vec[4]  = '{1'b0, 3'd1, 16'h0000, 16'h1111, 1'b0}; // fill index 1 with addr 1
    vec[5]  = '{1'b1, 3'd5, 16'h5555, 16'h0000, 1'b0}; // conflict write, line untouched
    vec[6]  = '{1'b0, 3'd1, 16'h0000, 16'h1111, 1'b1};
    vec[7]  = '{1'b0, 3'd5, 16'h0000, 16'h5555, 1'b0};
    vec[8]  = '{1'b1, 3'd5, 16'h0A0A, 16'h0000, 1'b1}; // write hit
    vec[9]  = '{1'b0, 3'd5, 16'h0000, 16'h0A0A, 1'b1};
    vec[10] = '{1'b0, 3'd2, 16'h0000, 16'h0102, 1'b0}; // untouched memory word
    vec[11] = '{1'b0, 3'd2, 16'h0000, 16'h0102, 1'b1};

    reset_n_i             = 1'b0;
    address_0_i           = '0;
    address_valid_0_i     = 1'b0;
    write_data_0_i        = '0;
    write_data_valid_0_i  = 1'b0;
    read_write_select_0_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_port_ready", 32'(port_ready_0_o), 32'd1);
    check("reset_rd_valid",   32'(read_data_valid_0_o), 32'd0);
    check("reset_wr_done",    32'(write_done_0_o), 32'd0);
    check("reset_mem_valid",  32'(mem_address_valid_0_o), 32'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("idle_port_ready",  32'(port_ready_0_o), 32'd1);

    last_rd = 16'h0000;
    for (int v = 0; v < 12; v++) begin
      rd0 = mem_reads;
      wr0 = mem_writes;
      do_req(vec[v].wr, vec[v].addr, vec[v].wdata, edges, to, seen);
      check($sformatf("v%0d_timeout", v), 32'(to), 32'd0);
      check($sformatf("v%0d_mem_reads", v), 32'(mem_reads - rd0),
            32'((!vec[v].wr && !vec[v].exp_hit) ? 1 : 0));
      check($sformatf("v%0d_mem_writes", v), 32'(mem_writes - wr0), 32'(vec[v].wr ? 1 : 0));
      if (vec[v].wr) begin
        check($sformatf("v%0d_rdata_hold", v), 32'(read_data_0_o), 32'(last_rd));
      end else begin
        check($sformatf("v%0d_rdata", v), 32'(read_data_0_o), 32'(vec[v].exp_rdata));
        last_rd = vec[v].exp_rdata;
        if (vec[v].exp_hit) begin
          check($sformatf("v%0d_hit_latency", v), 32'(edges), 32'd2);
          check($sformatf("v%0d_no_mem_traffic", v), 32'(seen), 32'd0);
        end
      end
    end

`ifdef DIRECT_MAPPED_CACHE_STATS_EN
    check("hit_count",  32'(hit_count_o),  32'd5);
    check("miss_count", 32'(miss_count_o), 32'd7);
`endif

    // Write without write data must be ignored.
    wr0 = mem_writes;
    @(negedge clk_i);
    address_0_i           = 3'd6;
    address_valid_0_i     = 1'b1;
    read_write_select_0_i = 1'b1;
    write_data_0_i        = 16'hDEAD;
    write_data_valid_0_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    check("nowdv_port_ready", 32'(port_ready_0_o), 32'd1);
    check("nowdv_mem_valid",  32'(mem_address_valid_0_o), 32'd0);
    address_valid_0_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("nowdv_mem_writes", 32'(mem_writes - wr0), 32'd0);

    // Reset while the cache waits on a memory read.
    rd0 = mem_reads;
    @(negedge clk_i);
    address_0_i           = 3'd3;
    address_valid_0_i     = 1'b1;
    read_write_select_0_i = 1'b0;
    @(negedge clk_i);
    address_valid_0_i = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_reads != rd0) begin
        to = 1'b0;
        break;
      end
      @(negedge clk_i);
    end
    check("abort_mem_accept_timeout", 32'(to), 32'd0);
    repeat (3) @(negedge clk_i);
    check("abort_busy", 32'(port_ready_0_o), 32'd0);
`ifdef DIRECT_MAPPED_CACHE_STATS_EN
    check("pre_reset_miss_count", 32'(miss_count_o), 32'd8);
`endif
    reset_n_i = 1'b0;
    #1;
    check("abort_port_ready", 32'(port_ready_0_o), 32'd1);
    check("abort_rd_valid",   32'(read_data_valid_0_o), 32'd0);
    check("abort_rdata",      32'(read_data_0_o), 32'd0);
    check("abort_mem_valid",  32'(mem_address_valid_0_o), 32'd0);
    check("abort_mem_wdv",    32'(mem_write_data_valid_0_o), 32'd0);
`ifdef DIRECT_MAPPED_CACHE_STATS_EN
    check("reset_hit_count",  32'(hit_count_o),  32'd0);
    check("reset_miss_count", 32'(miss_count_o), 32'd0);
`endif
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("abort_no_response", 32'(read_data_valid_0_o), 32'd0);

    // Address 5 was cached before reset; it must miss now (memory reloaded to 0x0105).
    rd0 = mem_reads;
    do_req(1'b0, 3'd5, 16'h0000, edges, to, seen);
    check("post_reset_timeout",   32'(to), 32'd0);
    check("post_reset_mem_reads", 32'(mem_reads - rd0), 32'd1);
    check("post_reset_rdata",     32'(read_data_0_o), 32'h0105);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
